// File: rtl/input_port_pkg.sv
`default_nettype none
// Shared definitions for the tiny16 input port: handshake states and status-word layout.
package input_port_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_CAPTURE = 2'd1,
    HS_WAIT_LO = 2'd2
  } hs_state_t;

  // Flag positions are counted down from the MSB so the layout scales with WIDTH.
  localparam int STAT_EMPTY_POS  = 1;
  localparam int STAT_FULL_POS   = 2;
  localparam int STAT_UFLOW_POS  = 3;
  localparam int STAT_COUNT_BITS = 3;

endpackage
`default_nettype wire

// File: rtl/input_port_sync_fifo.sv
`default_nettype none
// Single-clock FIFO holding words accepted from the producer until the CPU reads them.
module input_port_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/input_port.sv
`default_nettype none
// tiny16 input peripheral: 4-phase req/ack capture into a FIFO, read back over the CPU bus.
module input_port
  import input_port_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_req,
  input  logic [WIDTH-1:0] ext_data,
  output logic             ext_ack,
  input  logic             out_en,
  input  logic             stat_en,
  output logic [WIDTH-1:0] out,
  output logic             irq
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  hs_state_t              state;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   empty_next;
  logic [WIDTH-1:0]       head;
  logic [CW-1:0]          count;
  logic                   underflow;
  logic [WIDTH-1:0]       status;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) req_sync <= '0;
    else      req_sync <= {req_sync[SYNC_STAGES-2:0], ext_req};
  end

  assign req_s = req_sync[SYNC_STAGES-1];

  // The word is written and acked on the edge that enters CAPTURE, giving SYNC_STAGES+1 edges req->ack.
  assign push = (state == HS_IDLE) && req_s && !full;
  assign pop  = out_en && !stat_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HS_IDLE;
      ext_ack <= 1'b0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (push) begin
            state   <= HS_CAPTURE;
            ext_ack <= 1'b1;
          end
        end
        HS_CAPTURE: state <= HS_WAIT_LO;
        HS_WAIT_LO: begin
          if (!req_s) begin
            state   <= HS_IDLE;
            ext_ack <= 1'b0;
          end
        end
        default: begin
          state   <= HS_IDLE;
          ext_ack <= 1'b0;
        end
      endcase
    end
  end

  input_port_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (ext_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign empty_next = !push && ((count == '0) || ((count == CW'(1)) && pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (stat_en)                underflow <= 1'b0;
      else if (out_en && empty)   underflow <= 1'b1;
      irq <= !empty_next;
    end
  end

  always_comb begin
    status                            = '0;
    status[WIDTH-STAT_EMPTY_POS]      = empty;
    status[WIDTH-STAT_FULL_POS]       = full;
    status[WIDTH-STAT_UFLOW_POS]      = underflow;
    status[STAT_COUNT_BITS-1:0]       = STAT_COUNT_BITS'(count);
  end

  always_comb begin
    out = '0;
    if (stat_en)               out = status;
    else if (out_en && !empty) out = head;
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port.sv
`default_nettype none
// Randomized scoreboard bench for input_port against a queue-based model of the peripheral.
module tb_input_port;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ext_req = 1'b0;
  logic [WIDTH-1:0] ext_data = '0;
  logic             ext_ack;
  logic             out_en = 1'b0;
  logic             stat_en = 1'b0;
  logic [WIDTH-1:0] bus_out;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               model_uf = 1'b0;
  bit               prod_done = 1'b0;
  logic [WIDTH-1:0] exp_q[$];
  string            name_q[$];

  input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ext_req  (ext_req),
    .ext_data (ext_data),
    .ext_ack  (ext_ack),
    .out_en   (out_en),
    .stat_en  (stat_en),
    .out      (bus_out),
    .irq      (irq)
  );

  always #31 clk = ~clk;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_status();
    logic [WIDTH-1:0] s;
    s = '0;
    s[15] = (model_q.size() == 0);
    s[14] = (model_q.size() == DEPTH);
    s[13] = model_uf;
    s[2:0] = 3'(model_q.size());
    return s;
  endfunction

  // A word belongs to the FIFO from the moment the producer sees it acknowledged.
  always @(posedge ext_ack) if (rst) model_q.push_back(ext_data);

  // Monitor: compare the bus whenever the controller enables it.
  initial forever begin
    @(negedge clk);
    #2;
    if (out_en || stat_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL monitor: bus read %h with no expectation", bus_out);
      end else begin
        check(name_q.pop_front(), bus_out, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) check("irq", {15'b0, irq}, {15'b0, model_q.size() != 0});
  end

  task automatic bus_op(input bit oe, input bit se, input string nm);
    logic [WIDTH-1:0] e;
    @(negedge clk);
    out_en  = oe;
    stat_en = se;
    e = '0;
    if (se) begin
      e = model_status();
      model_uf = 1'b0;
    end else if (oe) begin
      if (model_q.size() == 0) model_uf = 1'b1;
      else                     e = model_q.pop_front();
    end
    if (oe || se) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    out_en  = 1'b0;
    stat_en = 1'b0;
  endtask

  task automatic wait_ack_low(input string nm);
    bit low;
    low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!ext_ack) begin
        low = 1'b1;
        break;
      end
    end
    if (!low) check({nm, "_ack_fall_timeout"}, {15'b0, ext_ack}, 16'h0);
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input int budget, output bit acked);
    ext_data = w;
    #1 ext_req = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (ext_ack) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      ext_req = 1'b0;
      wait_ack_low("send");
    end
  endtask

  task automatic random_producer(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      #($urandom_range(0, 200));
      send(16'($urandom), 400, ok);
      check("rand_ack", {15'b0, ok}, 16'h1);
      if (!ok) ext_req = 1'b0;
    end
    prod_done = 1'b1;
  endtask

  task automatic random_reader();
    int guard;
    int r;
    guard = 0;
    while ((!prod_done || model_q.size() != 0) && guard < 3000) begin
      guard++;
      r = $urandom_range(0, 99);
      if (r < 45)      bus_op(1'b1, 1'b0, "rand_pop");
      else if (r < 55) bus_op(1'b0, 1'b1, "rand_stat");
      else if (r < 60) bus_op(1'b1, 1'b1, "rand_both");
      else             @(negedge clk);
    end
    if (guard >= 3000) check("rand_reader_timeout", 16'(guard), 16'h0);
  endtask

  initial begin
    bit ok;

    // Power-on reset
    #5 rst = 1'b0;
    #1;
    check("reset_ack", {15'b0, ext_ack}, 16'h0);
    check("reset_irq", {15'b0, irq}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset while the handshake sits in WAIT_LO
    ext_data = 16'h1234;
    #1 ext_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ext_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("midhs_ack", {15'b0, ok}, 16'h1);
    @(negedge clk);
    #5 rst = 1'b0;
    model_q.delete();
    model_uf = 1'b0;
    #1;
    check("midhs_rst_ack", {15'b0, ext_ack}, 16'h0);
    check("midhs_rst_irq", {15'b0, irq}, 16'h0);
    ext_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_op(1'b0, 1'b1, "rst_status");
    check("rst_status_const", model_status(), 16'h8000);

    // Single word with exact ack latency
    @(negedge clk);
    ext_data = 16'hBEEF;
    ext_req  = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("rise_edge%0d", e), {15'b0, ext_ack}, {15'b0, e == 3});
    end
    ext_req = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("fall_edge%0d", e), {15'b0, ext_ack}, {15'b0, e != 3});
    end
    bus_op(1'b1, 1'b0, "single_read");
    bus_op(1'b0, 1'b1, "single_status");

    // Fill to full, then backpressure on the fifth word
    for (int k = 1; k <= 4; k++) begin
      send(16'(k), 50, ok);
      check("fill_ack", {15'b0, ok}, 16'h1);
    end
    check("fill_model_status", model_status(), 16'h4004);
    bus_op(1'b0, 1'b1, "fill_status");
    @(negedge clk);
    ext_data = 16'h0005;
    ext_req  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("full_backpressure", {15'b0, ext_ack}, 16'h0);
    bus_op(1'b1, 1'b0, "full_pop");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ext_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("fifth_acked", {15'b0, ok}, 16'h1);
    ext_req = 1'b0;
    wait_ack_low("fifth");
    repeat (4) bus_op(1'b1, 1'b0, "drain");

    // Underflow is sticky until a status read
    bus_op(1'b1, 1'b0, "uf_read");
    bus_op(1'b0, 1'b1, "uf_status");
    bus_op(1'b0, 1'b1, "uf_cleared");

    // Push and pop on the same edge with two words held
    send(16'hA001, 50, ok);
    send(16'hA002, 50, ok);
    @(negedge clk);
    ext_data = 16'hA003;
    ext_req  = 1'b1;
    @(negedge clk);
    bus_op(1'b1, 1'b0, "pushpop_read");
    check("pushpop_ack", {15'b0, ext_ack}, 16'h1);
    ext_req = 1'b0;
    wait_ack_low("pushpop");
    bus_op(1'b0, 1'b1, "pushpop_status");
    bus_op(1'b1, 1'b1, "both_enables");
    bus_op(1'b0, 1'b1, "both_no_pop");
    repeat (2) bus_op(1'b1, 1'b0, "pushpop_drain");

    // Randomized interleaving; pointers wrap many times
    prod_done = 1'b0;
    fork
      random_producer(30);
      random_reader();
    join
    bus_op(1'b0, 1'b1, "final_status");

    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(62 * 20000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
